usb_rx_packet: RTL and testbench

- Packet-level receiver. Sits directly downstream of the NRZI/de-stuffing bit decoder and consumes its decoded bit stream (bit plus bit-enable). The line sampler supplies an end-of-packet pulse.
- Hunts for SYNC, assembles bytes LSB-first, and validates the PID.
- Checks CRC5 on tokens and CRC16 on data packets, plus length and byte alignment.
- Reports one status pulse per packet to the protocol engine.

---
 rtl/usb_rx_packet.sv | 269 ++++++++++++++++++++++++++
 tb/tb_usb_rx_packet.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_packet.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : usb_rx_packet
//  Function : USB packet receiver. Hunts SYNC in the decoded bit stream,
//             assembles bytes LSB-first, validates the PID, checks CRC5 on
//             tokens and CRC16 on data packets, length and byte alignment,
//             and reports one status pulse per packet.
//  Revision : 1.0 - initial release
// ============================================================================
module usb_rx_packet #(
    parameter int MAX_BYTES = 1027,
    parameter int CNT_W     = 11
) (
    input  logic             i_clk_48mhz,
    input  logic             i_rst,
    input  logic             i_bit,
    input  logic             i_bit_en,
    input  logic             i_eop,
    output logic [7:0]       o_byte,
    output logic             o_byte_valid,
    output logic             o_pkt_start,
    output logic             o_pkt_done,
    output logic             o_pkt_ok,
    output logic [3:0]       o_pid,
    output logic [CNT_W-1:0] o_pkt_len,
    output logic             o_err_pid,
    output logic             o_err_crc,
    output logic             o_err_len,
    output logic             o_err_align
);

    localparam logic [1:0] c_ST_HUNT = 2'd0;
    localparam logic [1:0] c_ST_PID  = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;

    localparam logic [1:0] c_TYPE_SPECIAL = 2'b00;
    localparam logic [1:0] c_TYPE_TOKEN   = 2'b01;
    localparam logic [1:0] c_TYPE_HS      = 2'b10;
    localparam logic [1:0] c_TYPE_DATA    = 2'b11;

    localparam logic [4:0]  c_CRC5_INIT   = 5'h1F;
    localparam logic [4:0]  c_CRC5_POLY   = 5'h05;
    localparam logic [4:0]  c_CRC5_RESID  = 5'h0C;
    localparam logic [15:0] c_CRC16_INIT  = 16'hFFFF;
    localparam logic [15:0] c_CRC16_POLY  = 16'h8005;
    localparam logic [15:0] c_CRC16_RESID = 16'h800D;

    localparam logic [CNT_W-1:0] c_MAX_LEN = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0] c_SAT_LEN = CNT_W'(MAX_BYTES + 1);

    logic [1:0]       state_q,      state_d;
    logic [7:0]       sr_q,         sr_d;
    logic [2:0]       bit_cnt_q,    bit_cnt_d;
    logic [CNT_W-1:0] byte_cnt_q,   byte_cnt_d;
    logic [4:0]       crc5_q,       crc5_d;
    logic [15:0]      crc16_q,      crc16_d;
    logic [1:0]       pkt_type_q,   pkt_type_d;
    logic             pid_err_q,    pid_err_d;
    logic             ovf_q,        ovf_d;
    logic [7:0]       rx_byte_q,    rx_byte_d;
    logic             byte_valid_q, byte_valid_d;
    logic             pkt_start_q,  pkt_start_d;
    logic             pkt_done_q,   pkt_done_d;
    logic             pkt_ok_q,     pkt_ok_d;
    logic [3:0]       pid_q,        pid_d;
    logic [CNT_W-1:0] pkt_len_q,    pkt_len_d;
    logic             err_pid_q,    err_pid_d;
    logic             err_crc_q,    err_crc_d;
    logic             err_len_q,    err_len_d;
    logic             err_align_q,  err_align_d;

    logic        w_in_pkt;
    logic        w_eop;
    logic        w_shift;
    logic        w_sync;
    logic        w_byte_done;
    logic [7:0]  w_sr_next;
    logic        w_crc5_fb;
    logic        w_crc16_fb;
    logic        w_crc_bad;
    logic        w_len_bad;
    logic        w_align_bad;

    // Event decode: EOP only matters inside a packet and then swallows a coincident bit
    always_comb begin
        w_in_pkt    = (state_q != c_ST_HUNT);
        w_eop       = i_eop & w_in_pkt;
        w_shift     = i_bit_en & ~w_eop;
        w_sr_next   = {i_bit, sr_q[7:1]};
        w_sync      = ~w_in_pkt & i_bit_en & i_bit & (sr_q[7:5] == 3'b000);
        w_byte_done = w_in_pkt & w_shift & (bit_cnt_q == 3'd7);
        w_crc5_fb   = crc5_q[4] ^ i_bit;
        w_crc16_fb  = crc16_q[15] ^ i_bit;
    end

    // End-of-packet verdict, evaluated from the state accumulated so far
    always_comb begin
        w_crc_bad   = 1'b0;
        w_len_bad   = ovf_q;
        w_align_bad = (state_q == c_ST_PID) | (bit_cnt_q != 3'd0);
        case (pkt_type_q)
            c_TYPE_TOKEN: begin
                w_crc_bad = (crc5_q != c_CRC5_RESID);
                if (byte_cnt_q != CNT_W'(3)) w_len_bad = 1'b1;
            end
            c_TYPE_HS: begin
                if (byte_cnt_q != CNT_W'(1)) w_len_bad = 1'b1;
            end
            c_TYPE_DATA: begin
                w_crc_bad = (crc16_q != c_CRC16_RESID);
                if (byte_cnt_q < CNT_W'(3)) w_len_bad = 1'b1;
            end
            default: ;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk_48mhz) begin
        if (i_rst) begin
            state_q <= c_ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_HUNT: if (w_sync) state_d = c_ST_PID;
            c_ST_PID: begin
                if (w_eop)            state_d = c_ST_HUNT;
                else if (w_byte_done) state_d = c_ST_DATA;
            end
            c_ST_DATA: if (w_eop) state_d = c_ST_HUNT;
            default: state_d = c_ST_HUNT;
        endcase
    end

    // FSM outputs and datapath next values
    always_comb begin
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        crc5_d       = crc5_q;
        crc16_d      = crc16_q;
        pkt_type_d   = pkt_type_q;
        pid_err_d    = pid_err_q;
        ovf_d        = ovf_q;
        rx_byte_d    = rx_byte_q;
        byte_valid_d = 1'b0;
        pkt_start_d  = 1'b0;
        pkt_done_d   = 1'b0;
        pkt_ok_d     = pkt_ok_q;
        pid_d        = pid_q;
        pkt_len_d    = pkt_len_q;
        err_pid_d    = err_pid_q;
        err_crc_d    = err_crc_q;
        err_len_d    = err_len_q;
        err_align_d  = err_align_q;

        if (w_shift) sr_d = w_sr_next;

        if (w_sync) begin
            // Fresh packet context; type defaults to special until the PID lands
            pkt_start_d = 1'b1;
            bit_cnt_d   = 3'd0;
            byte_cnt_d  = '0;
            crc5_d      = c_CRC5_INIT;
            crc16_d     = c_CRC16_INIT;
            pkt_type_d  = c_TYPE_SPECIAL;
            pid_err_d   = 1'b0;
            ovf_d       = 1'b0;
        end

        if (w_in_pkt && w_shift) bit_cnt_d = bit_cnt_q + 3'd1;

        // CRCs cover every bit after the PID byte
        if ((state_q == c_ST_DATA) && w_shift) begin
            crc5_d  = {crc5_q[3:0], 1'b0} ^ (w_crc5_fb ? c_CRC5_POLY : 5'h00);
            crc16_d = {crc16_q[14:0], 1'b0} ^ (w_crc16_fb ? c_CRC16_POLY : 16'h0000);
        end

        if (w_byte_done) begin
            rx_byte_d    = w_sr_next;
            byte_valid_d = 1'b1;
            if (state_q == c_ST_PID) begin
                pid_d      = w_sr_next[3:0];
                pid_err_d  = (w_sr_next[7:4] != ~w_sr_next[3:0]);
                pkt_type_d = w_sr_next[1:0];
                byte_cnt_d = CNT_W'(1);
            end else begin
                // Count saturates one past the limit so the overrun stays visible
                if (byte_cnt_q != c_SAT_LEN) byte_cnt_d = byte_cnt_q + CNT_W'(1);
                if (byte_cnt_q >= c_MAX_LEN) ovf_d = 1'b1;
            end
        end

        if (w_eop) begin
            pkt_done_d  = 1'b1;
            pkt_len_d   = byte_cnt_q;
            err_pid_d   = pid_err_q;
            err_crc_d   = w_crc_bad;
            err_len_d   = w_len_bad;
            err_align_d = w_align_bad;
            pkt_ok_d    = ~(pid_err_q | w_crc_bad | w_len_bad | w_align_bad);
        end
    end

    // Datapath and output registers
    always_ff @(posedge i_clk_48mhz) begin
        if (i_rst) begin
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            crc5_q       <= c_CRC5_INIT;
            crc16_q      <= c_CRC16_INIT;
            pkt_type_q   <= c_TYPE_SPECIAL;
            pid_err_q    <= 1'b0;
            ovf_q        <= 1'b0;
            rx_byte_q    <= '0;
            byte_valid_q <= 1'b0;
            pkt_start_q  <= 1'b0;
            pkt_done_q   <= 1'b0;
            pkt_ok_q     <= 1'b0;
            pid_q        <= '0;
            pkt_len_q    <= '0;
            err_pid_q    <= 1'b0;
            err_crc_q    <= 1'b0;
            err_len_q    <= 1'b0;
            err_align_q  <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            crc5_q       <= crc5_d;
            crc16_q      <= crc16_d;
            pkt_type_q   <= pkt_type_d;
            pid_err_q    <= pid_err_d;
            ovf_q        <= ovf_d;
            rx_byte_q    <= rx_byte_d;
            byte_valid_q <= byte_valid_d;
            pkt_start_q  <= pkt_start_d;
            pkt_done_q   <= pkt_done_d;
            pkt_ok_q     <= pkt_ok_d;
            pid_q        <= pid_d;
            pkt_len_q    <= pkt_len_d;
            err_pid_q    <= err_pid_d;
            err_crc_q    <= err_crc_d;
            err_len_q    <= err_len_d;
            err_align_q  <= err_align_d;
        end
    end

    assign o_byte       = rx_byte_q;
    assign o_byte_valid = byte_valid_q;
    assign o_pkt_start  = pkt_start_q;
    assign o_pkt_done   = pkt_done_q;
    assign o_pkt_ok     = pkt_ok_q;
    assign o_pid        = pid_q;
    assign o_pkt_len    = pkt_len_q;
    assign o_err_pid    = err_pid_q;
    assign o_err_crc    = err_crc_q;
    assign o_err_len    = err_len_q;
    assign o_err_align  = err_align_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_packet.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_usb_rx_packet
//  Function : Self-checking bench for usb_rx_packet. Packets are built from
//             USB framing rules (CRC generated over the payload and appended
//             inverted, MSB first) and the expected status is derived from
//             the packet contents.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_usb_rx_packet;

    localparam int MAX_BYTES = 1027;
    localparam int CNT_W     = 11;

    typedef struct packed {
        logic             ok;
        logic             ep;
        logic             ec;
        logic             el;
        logic             ea;
        logic [3:0]       pid;
        logic [CNT_W-1:0] len;
    } res_t;

    logic             clk = 1'b0;
    logic             i_rst;
    logic             i_bit;
    logic             i_bit_en;
    logic             i_eop;
    logic [7:0]       o_byte;
    logic             o_byte_valid;
    logic             o_pkt_start;
    logic             o_pkt_done;
    logic             o_pkt_ok;
    logic [3:0]       o_pid;
    logic [CNT_W-1:0] o_pkt_len;
    logic             o_err_pid;
    logic             o_err_crc;
    logic             o_err_len;
    logic             o_err_align;

    int   checks = 0;
    int   errors = 0;
    int   n_start_total = 0;
    int   n_done_total  = 0;
    int   start_base, done_base, byte_base;
    logic done_now;
    res_t got_res;
    res_t exp_res;
    res_t mask_all;
    res_t mask_nocrc;
    logic [7:0] pkt[$];
    logic [7:0] got_bytes[$];
    logic [30:0] all_out;

    usb_rx_packet #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) dut (
        .i_clk_48mhz (clk),
        .i_rst       (i_rst),
        .i_bit       (i_bit),
        .i_bit_en    (i_bit_en),
        .i_eop       (i_eop),
        .o_byte      (o_byte),
        .o_byte_valid(o_byte_valid),
        .o_pkt_start (o_pkt_start),
        .o_pkt_done  (o_pkt_done),
        .o_pkt_ok    (o_pkt_ok),
        .o_pid       (o_pid),
        .o_pkt_len   (o_pkt_len),
        .o_err_pid   (o_err_pid),
        .o_err_crc   (o_err_crc),
        .o_err_len   (o_err_len),
        .o_err_align (o_err_align)
    );

    always #10 clk = ~clk;

    assign all_out = {o_byte, o_byte_valid, o_pkt_start, o_pkt_done, o_pkt_ok, o_pid,
                      o_pkt_len, o_err_pid, o_err_crc, o_err_len, o_err_align};

    // Passive capture of DUT strobes, sampled mid-cycle
    always @(negedge clk) begin
        if (o_byte_valid) got_bytes.push_back(o_byte);
        if (o_pkt_start) n_start_total <= n_start_total + 1;
        if (o_pkt_done) begin
            n_done_total <= n_done_total + 1;
            got_res <= '{ok: o_pkt_ok, ep: o_err_pid, ec: o_err_crc, el: o_err_len,
                         ea: o_err_align, pid: o_pid, len: o_pkt_len};
        end
    end

    // ---------------------------------------------------------------- model
    function automatic logic [4:0] crc5_calc(input logic [10:0] v);
        logic [4:0] c;
        logic       fb;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            fb = c[4] ^ v[i];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
        end
        return c;
    endfunction

    // CRC16 over pkt[first .. last-1]
    function automatic logic [15:0] crc16_calc(input int first, input int last);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int k = first; k < last; k++)
            for (int b = 0; b < 8; b++) begin
                fb = c[15] ^ pkt[k][b];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
        return c;
    endfunction

    // Wire order is inverted CRC, MSB first; field bit j is the j-th bit sent
    function automatic logic [4:0] crc5_field(input logic [4:0] c);
        logic [4:0] f;
        for (int j = 0; j < 5; j++) f[j] = ~c[4-j];
        return f;
    endfunction

    function automatic logic [15:0] crc16_field(input logic [15:0] c);
        logic [15:0] f;
        for (int j = 0; j < 16; j++) f[j] = ~c[15-j];
        return f;
    endfunction

    function automatic res_t model_result(input int extra_bits);
        res_t        r;
        int          n;
        logic [15:0] w;
        n = pkt.size();
        r = '0;
        r.len = (n > MAX_BYTES) ? CNT_W'(MAX_BYTES + 1) : CNT_W'(n);
        r.pid = pkt[0][3:0];
        r.ep  = (pkt[0][7:4] != ~pkt[0][3:0]);
        r.ea  = (extra_bits != 0);
        case (pkt[0][1:0])
            2'b01: begin
                r.el = (n != 3);
                if (n == 3) begin
                    w = {pkt[2], pkt[1]};
                    r.ec = (w[15:11] != crc5_field(crc5_calc(w[10:0])));
                end
            end
            2'b10: r.el = (n != 1);
            2'b11: begin
                r.el = (n < 3);
                if (n >= 3) r.ec = ({pkt[n-1], pkt[n-2]} != crc16_field(crc16_calc(1, n - 2)));
            end
            default: ;
        endcase
        if (n > MAX_BYTES) r.el = 1'b1;
        r.ok = ~(r.ep | r.ec | r.el | r.ea);
        return r;
    endfunction

    function automatic logic bytes_match();
        if (got_bytes.size() - byte_base != pkt.size()) return 1'b0;
        foreach (pkt[i]) if (got_bytes[byte_base + i] !== pkt[i]) return 1'b0;
        return 1'b1;
    endfunction

    // ------------------------------------------------------------ builders
    task automatic make_token(input logic [7:0] pid, input logic corrupt);
        logic [15:0] w;
        w[10:0]  = 11'($urandom);
        w[15:11] = crc5_field(crc5_calc(w[10:0]));
        if (corrupt) w[$urandom_range(0, 15)] ^= 1'b1;
        pkt.delete();
        pkt.push_back(pid);
        pkt.push_back(w[7:0]);
        pkt.push_back(w[15:8]);
    endtask

    task automatic make_data(input logic [7:0] pid, input int nbytes, input logic corrupt);
        logic [15:0] f;
        int          idx;
        pkt.delete();
        pkt.push_back(pid);
        for (int i = 0; i < nbytes; i++) pkt.push_back(8'($urandom));
        f = crc16_field(crc16_calc(1, pkt.size()));
        pkt.push_back(f[7:0]);
        pkt.push_back(f[15:8]);
        if (corrupt) begin
            idx = $urandom_range(1, pkt.size() - 1);
            pkt[idx][$urandom_range(0, 7)] ^= 1'b1;
        end
    endtask

    // ------------------------------------------------------------- drivers
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic put_bit(input logic b, input int max_gap);
        i_bit    = b;
        i_bit_en = 1'b1;
        @(posedge clk); #1;
        i_bit_en = 1'b0;
        idle($urandom_range(0, max_gap));
    endtask

    task automatic send_packet(input int sync_zeros, input int extra_bits,
                               input int max_gap, input logic eop_with_bit);
        start_base = n_start_total;
        done_base  = n_done_total;
        byte_base  = got_bytes.size();
        for (int i = 0; i < sync_zeros; i++) put_bit(1'b0, max_gap);
        put_bit(1'b1, max_gap);
        foreach (pkt[k]) for (int b = 0; b < 8; b++) put_bit(pkt[k][b], max_gap);
        for (int i = 0; i < extra_bits; i++) put_bit(1'($urandom_range(0, 1)), max_gap);
        i_eop    = 1'b1;
        i_bit_en = eop_with_bit;
        i_bit    = 1'b1;
        @(posedge clk); #1;
        i_eop    = 1'b0;
        i_bit_en = 1'b0;
        done_now = o_pkt_done;
        idle(3);
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
    endtask

    task automatic test_handshake();
        logic [7:0] hs[3];
        hs[0] = 8'hD2; hs[1] = 8'h5A; hs[2] = 8'h1E;
        for (int t = 0; t < 4; t++) begin
            pkt.delete();
            pkt.push_back((t == 0) ? 8'hD2 : hs[$urandom_range(0, 2)]);
            send_packet(7, 0, 2, 1'b0);
            exp_res = model_result(0);
            checks++;
            if (n_start_total - start_base != 1 || n_done_total - done_base != 1 || done_now !== 1'b1) begin
                errors++;
                $display("FAIL hs_pulses: starts %0d dones %0d done_at_latency %b, required 1 1 1",
                         n_start_total - start_base, n_done_total - done_base, done_now);
            end
            checks++;
            if (!bytes_match()) begin
                errors++;
                $display("FAIL hs_bytes: got %0d bytes, required %0d (pid %h)",
                         got_bytes.size() - byte_base, pkt.size(), pkt[0]);
            end
            checks++;
            if (((got_res ^ exp_res) & mask_all) !== '0) begin
                errors++;
                $display("FAIL hs_result: got %h required %h", got_res, exp_res);
            end
        end
    endtask

    task automatic test_token();
        logic [7:0] tok[4];
        tok[0] = 8'hE1; tok[1] = 8'h69; tok[2] = 8'hA5; tok[3] = 8'h2D;
        for (int t = 0; t < 8; t++) begin
            if (t < 2) begin
                pkt.delete();
                pkt.push_back(8'h2D); pkt.push_back(8'h00);
                pkt.push_back((t == 0) ? 8'h10 : 8'h14);
            end else begin
                make_token(tok[$urandom_range(0, 3)], ($urandom_range(0, 2) == 0));
            end
            send_packet(7, 0, 2, 1'b0);
            exp_res = model_result(0);
            checks++;
            if (t == 0 && exp_res.ok !== 1'b1) begin
                errors++;
                $display("FAIL token_model_setup: model ok %b required 1", exp_res.ok);
            end
            checks++;
            if (!bytes_match() || n_done_total - done_base != 1) begin
                errors++;
                $display("FAIL token_bytes: got %0d bytes %0d dones, required %0d bytes 1 done",
                         got_bytes.size() - byte_base, n_done_total - done_base, pkt.size());
            end
            checks++;
            if (((got_res ^ exp_res) & mask_all) !== '0) begin
                errors++;
                $display("FAIL token_result: got %h required %h (pkt %h %h %h)",
                         got_res, exp_res, pkt[0], pkt[1], pkt[2]);
            end
        end
    endtask

    task automatic test_data();
        logic [7:0] dp[4];
        dp[0] = 8'hC3; dp[1] = 8'h4B; dp[2] = 8'h87; dp[3] = 8'h0F;
        for (int t = 0; t < 8; t++) begin
            if (t < 2) begin
                pkt.delete();
                pkt.push_back((t == 0) ? 8'h4B : 8'hC3);
                pkt.push_back(8'h00);
                pkt.push_back((t == 0) ? 8'h00 : 8'h01);
            end else begin
                make_data(dp[$urandom_range(0, 3)], $urandom_range(0, 16), ($urandom_range(0, 2) == 0));
            end
            send_packet(7, 0, 2, 1'b0);
            exp_res = model_result(0);
            checks++;
            if (!bytes_match() || n_done_total - done_base != 1) begin
                errors++;
                $display("FAIL data_bytes: got %0d bytes %0d dones, required %0d bytes 1 done",
                         got_bytes.size() - byte_base, n_done_total - done_base, pkt.size());
            end
            checks++;
            if (((got_res ^ exp_res) & mask_all) !== '0) begin
                errors++;
                $display("FAIL data_result: got %h required %h (len %0d)", got_res, exp_res, pkt.size());
            end
        end
    endtask

    task automatic test_bad_pid_and_len();
        pkt.delete();
        pkt.push_back(8'hD3);
        send_packet(7, 0, 1, 1'b0);
        exp_res = model_result(0);
        checks++;
        if (((got_res ^ exp_res) & mask_nocrc) !== '0 || got_res.ep !== 1'b1) begin
            errors++;
            $display("FAIL bad_pid: got %h required %h (crc ignored)", got_res, exp_res);
        end
        pkt.delete();
        pkt.push_back(8'hE1);
        pkt.push_back(8'($urandom));
        send_packet(7, 0, 1, 1'b0);
        exp_res = model_result(0);
        checks++;
        if (((got_res ^ exp_res) & mask_nocrc) !== '0 || got_res.el !== 1'b1) begin
            errors++;
            $display("FAIL short_token: got %h required %h (crc ignored)", got_res, exp_res);
        end
        pkt.delete();
        pkt.push_back(8'hD2);
        pkt.push_back(8'h00);
        send_packet(7, 0, 1, 1'b0);
        exp_res = model_result(0);
        checks++;
        if (((got_res ^ exp_res) & mask_all) !== '0) begin
            errors++;
            $display("FAIL long_handshake: got %h required %h", got_res, exp_res);
        end
    endtask

    task automatic test_align_and_collision();
        pkt.delete();
        pkt.push_back(8'hD2);
        send_packet(7, 4, 1, 1'b0);
        exp_res = model_result(4);
        checks++;
        if (((got_res ^ exp_res) & mask_all) !== '0) begin
            errors++;
            $display("FAIL align_partial: got %h required %h", got_res, exp_res);
        end
        pkt.delete();
        send_packet(7, 3, 1, 1'b0);
        checks++;
        if (n_done_total - done_base != 1 || got_res.ea !== 1'b1 || got_res.ok !== 1'b0 ||
            got_res.len !== '0) begin
            errors++;
            $display("FAIL align_in_pid: dones %0d ea %b ok %b len %0d, required 1 1 0 0",
                     n_done_total - done_base, got_res.ea, got_res.ok, got_res.len);
        end
        pkt.delete();
        pkt.push_back(8'hD2);
        send_packet(7, 0, 1, 1'b1);
        exp_res = model_result(0);
        checks++;
        if (done_now !== 1'b1 || ((got_res ^ exp_res) & mask_all) !== '0) begin
            errors++;
            $display("FAIL eop_bit_collision: done %b got %h required 1 %h", done_now, got_res, exp_res);
        end
    endtask

    task automatic test_robustness();
        // Reset in the middle of a data packet
        done_base = n_done_total;
        make_data(8'hC3, 6, 1'b0);
        for (int i = 0; i < 7; i++) put_bit(1'b0, 1);
        put_bit(1'b1, 1);
        for (int k = 0; k < 4; k++) for (int b = 0; b < 8; b++) put_bit(pkt[k][b], 1);
        put_bit(1'b1, 0);
        i_rst = 1'b1;
        idle(1);
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h expected 0", all_out);
        end
        idle(1);
        i_rst = 1'b0;
        idle(4);
        checks++;
        if (n_done_total - done_base != 0) begin
            errors++;
            $display("FAIL reset_mid_done: got %0d dones required 0", n_done_total - done_base);
        end
        // Truncated SYNC after reset, plain ACK
        pkt.delete();
        pkt.push_back(8'hD2);
        send_packet(4, 0, 1, 1'b0);
        exp_res = model_result(0);
        checks++;
        if (n_start_total - start_base != 1 || !bytes_match() ||
            ((got_res ^ exp_res) & mask_all) !== '0) begin
            errors++;
            $display("FAIL trunc_sync_ack: starts %0d got %h required 1 %h",
                     n_start_total - start_base, got_res, exp_res);
        end
        // Stray EOP while hunting
        start_base = n_start_total;
        done_base  = n_done_total;
        byte_base  = got_bytes.size();
        i_eop = 1'b1;
        idle(1);
        i_eop = 1'b0;
        idle(5);
        checks++;
        if (n_start_total != start_base || n_done_total != done_base || got_bytes.size() != byte_base) begin
            errors++;
            $display("FAIL stray_eop: starts %0d dones %0d bytes %0d, required 0 0 0",
                     n_start_total - start_base, n_done_total - done_base, got_bytes.size() - byte_base);
        end
    endtask

    task automatic test_overlength();
        int sizes[2];
        sizes[0] = MAX_BYTES;
        sizes[1] = MAX_BYTES + 3;
        for (int s = 0; s < 2; s++) begin
            pkt.delete();
            pkt.push_back(8'h3C);
            for (int i = 1; i < sizes[s]; i++) pkt.push_back(8'($urandom));
            send_packet(7, 0, 0, 1'b0);
            exp_res = model_result(0);
            checks++;
            if (!bytes_match() || ((got_res ^ exp_res) & mask_all) !== '0) begin
                errors++;
                $display("FAIL overlength_%0d: bytes %0d got %h required %h",
                         sizes[s], got_bytes.size() - byte_base, got_res, exp_res);
            end
        end
    endtask

    initial begin
        mask_all      = '1;
        mask_nocrc    = '1;
        mask_nocrc.ec = 1'b0;
        i_rst    = 1'b1;
        i_bit    = 1'b0;
        i_bit_en = 1'b0;
        i_eop    = 1'b0;
        @(posedge clk); #1;
        idle(3);
        test_reset();
        i_rst = 1'b0;
        idle(2);
        test_handshake();
        test_token();
        test_data();
        test_bad_pid_and_len();
        test_align_and_collision();
        test_robustness();
        test_overlength();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
